// File: rtl/sal_rdwr_sched_if.sv
// Read/write scheduler bus: request side in, grants and mode out.
// slave is the scheduler, master is whoever drives the queues.
interface sal_rdwr_sched_if #(
  parameter int CNT_W = 4
);
  logic             rd_req_i;
  logic             wr_req_i;
  logic             wr_data_rdy_i;
  logic [CNT_W-1:0] wr_cnt_i;
  logic             cmd_rdy_i;
  logic [2:0]       t_ccd_i;
  logic [3:0]       t_rtw_i;
  logic [3:0]       t_wtr_i;
  logic             rd_gnt_o;
  logic             wr_gnt_o;
  logic             mode_o;
  logic [1:0]       state_o;

  modport slave (
    input  rd_req_i, wr_req_i, wr_data_rdy_i,
    input  wr_cnt_i, cmd_rdy_i,
    input  t_ccd_i, t_rtw_i, t_wtr_i,
    output rd_gnt_o, wr_gnt_o, mode_o, state_o
  );

  modport master (
    output rd_req_i, wr_req_i, wr_data_rdy_i,
    output wr_cnt_i, cmd_rdy_i,
    output t_ccd_i, t_rtw_i, t_wtr_i,
    input  rd_gnt_o, wr_gnt_o, mode_o, state_o
  );
endinterface

// File: rtl/sal_rdwr_sched.sv
// DDR2 data-bus direction scheduler: picks read or write mode,
// enforces turnaround gaps, tCCD spacing and watermark write drains.
module sal_rdwr_sched #(
  parameter int CNT_W        = 4,
  parameter int HI_WM        = 6,
  parameter int LO_WM        = 2,
  parameter int WR_BURST_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sal_rdwr_sched_if.slave    bus
);

  typedef enum logic [1:0] {
    RD  = 2'd0,
    R2W = 2'd1,
    WR  = 2'd2,
    W2R = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] L_HI = CNT_W'(HI_WM);
  localparam logic [CNT_W-1:0] L_LO = CNT_W'(LO_WM);
  localparam logic [2:0]       L_BM = 3'(WR_BURST_MAX);

  state_t     r_state;
  logic [3:0] r_tcnt;
  logic [2:0] r_ccd;
  logic [2:0] r_burst;
  logic       r_drain;

  logic w_hi;
  logic w_lo;
  logic w_sw;
  logic w_rd_gnt;
  logic w_wr_gnt;

  assign w_hi = bus.wr_cnt_i >= L_HI;
  assign w_lo = bus.wr_cnt_i <= L_LO;

  // switch condition of the current state; beats any grant
  always_comb begin
    w_sw = 1'b0;
    case (r_state)
      RD: w_sw = w_hi
            | (~bus.rd_req_i & bus.wr_req_i
               & bus.wr_data_rdy_i);
      WR: w_sw = bus.rd_req_i
            & (~bus.wr_req_i | ~bus.wr_data_rdy_i
               | (~r_drain & (r_burst == L_BM))
               | (r_drain & w_lo));
      default: w_sw = 1'b0;
    endcase
  end

  assign w_rd_gnt = (r_state == RD) & bus.rd_req_i
                  & bus.cmd_rdy_i & (r_ccd == 3'd0)
                  & ~w_sw;
  assign w_wr_gnt = (r_state == WR) & bus.wr_req_i
                  & bus.wr_data_rdy_i & bus.cmd_rdy_i
                  & (r_ccd == 3'd0) & ~w_sw;

  assign bus.rd_gnt_o = rst_n & w_rd_gnt;
  assign bus.wr_gnt_o = rst_n & w_wr_gnt;
  assign bus.mode_o   = rst_n & r_state[1] ^ (rst_n & r_state[0] & ~r_state[1])
                      ^ (rst_n & r_state[0] & r_state[1]);
  assign bus.state_o  = rst_n ? r_state : RD;

  // direction FSM with turnaround, spacing and burst counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RD;
      r_tcnt  <= 4'd0;
      r_ccd   <= 3'd0;
      r_burst <= 3'd0;
      r_drain <= 1'b0;
    end else begin
      if (w_rd_gnt || w_wr_gnt)
        r_ccd <= (bus.t_ccd_i == 3'd0) ? 3'd0
                                       : bus.t_ccd_i - 3'd1;
      else if (r_ccd != 3'd0)
        r_ccd <= r_ccd - 3'd1;

      if (w_wr_gnt && r_burst != L_BM)
        r_burst <= r_burst + 3'd1;

      case (r_state)
        RD: if (w_sw) begin
          r_state <= R2W;
          r_tcnt  <= bus.t_rtw_i;
          r_drain <= w_hi;
        end
        R2W: if (r_tcnt <= 4'd1) begin
          r_state <= WR;
          r_burst <= 3'd0;
        end else begin
          r_tcnt <= r_tcnt - 4'd1;
        end
        WR: if (w_sw) begin
          r_state <= W2R;
          r_tcnt  <= bus.t_wtr_i;
          r_drain <= 1'b0;
        end
        W2R: if (r_tcnt <= 4'd1) begin
          r_state <= RD;
        end else begin
          r_tcnt <= r_tcnt - 4'd1;
        end
        default: r_state <= RD;
      endcase
    end
  end

endmodule
